// File: rtl/pipeline_pkg.sv
`default_nettype none
// ============================================================================
// Package  : pipeline_pkg
// Summary  : Shared opcodes, funct3 encodings and MEM-stage FSM state type
//            for the five-stage pipeline.
// Revision : 1.0 - initial release
// ============================================================================
package pipeline_pkg;

  // Major opcodes (instruction bits [6:0])
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_OPIMM  = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  // Load/store size and signedness encodings
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  // Memory-access FSM: IDLE waits for a good op, REQ holds the bus request
  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_REQ  = 1'b1
  } mem_state_e;

  // Stores only have signed-size encodings; loads add the unsigned variants
  function automatic logic f3_legal(input logic [2:0] f3, input logic is_store);
    logic ok;
    ok = (f3 == F3_SB) || (f3 == F3_SH) || (f3 == F3_SW);
    if (!is_store) begin
      ok = ok || (f3 == F3_LBU) || (f3 == F3_LHU);
    end
    return ok;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_lane_align.sv
`default_nettype none
// ============================================================================
// Module   : mem_lane_align
// Summary  : Byte-lane steering for the MEM stage. Store side produces the
//            strobes, replicated write data and the bad-op flag; load side
//            picks the addressed lane and sign/zero-extends it.
// Revision : 1.0 - initial release
// ============================================================================
module mem_lane_align
  import pipeline_pkg::*;
(
  input  logic [1:0]  i_addr_lo,
  input  logic [2:0]  i_funct3,
  input  logic        i_is_store,
  input  logic [31:0] i_rs2,
  input  logic [31:0] i_rdata,
  output logic [3:0]  o_wstrb,
  output logic [31:0] o_wdata,
  output logic        o_bad,
  output logic [31:0] o_result
);

  logic        w_aligned;
  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Store strobes and lane-replicated data; misaligned shifts are masked by o_bad
  always_comb begin
    o_wstrb = 4'b0000;
    o_wdata = i_rs2;
    case (i_funct3)
      F3_SB: begin
        o_wstrb = 4'b0001 << i_addr_lo;
        o_wdata = {4{i_rs2[7:0]}};
      end
      F3_SH: begin
        o_wstrb = 4'b0011 << i_addr_lo;
        o_wdata = {2{i_rs2[15:0]}};
      end
      F3_SW: begin
        o_wstrb = 4'b1111;
        o_wdata = i_rs2;
      end
      default: begin
        o_wstrb = 4'b0000;
        o_wdata = i_rs2;
      end
    endcase
  end

  // An op is bad when its encoding is illegal or its address is not size-aligned
  always_comb begin
    case (i_funct3[1:0])
      2'b01:   w_aligned = ~i_addr_lo[0];
      2'b10:   w_aligned = (i_addr_lo == 2'b00);
      default: w_aligned = 1'b1;
    endcase
    o_bad = ~f3_legal(i_funct3, i_is_store) | ~w_aligned;
  end

  // Load lane select followed by sign or zero extension
  always_comb begin
    case (i_addr_lo)
      2'd0:    w_byte = i_rdata[7:0];
      2'd1:    w_byte = i_rdata[15:8];
      2'd2:    w_byte = i_rdata[23:16];
      default: w_byte = i_rdata[31:24];
    endcase
    w_half = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];
    case (i_funct3)
      F3_LB:   o_result = {{24{w_byte[7]}}, w_byte};
      F3_LBU:  o_result = {24'd0, w_byte};
      F3_LH:   o_result = {{16{w_half[15]}}, w_half};
      F3_LHU:  o_result = {16'd0, w_half};
      default: o_result = i_rdata;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/mem_stage.sv
`default_nettype none
// ============================================================================
// Module   : mem_stage
// Summary  : Pipeline memory stage. Issues data-memory loads/stores over a
//            req/ack bus, stalls upstream while an access is outstanding,
//            aborts on timeout and produces the registered MEM/WB triple.
// Revision : 1.0 - initial release
// ============================================================================
module mem_stage
  import pipeline_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        EX_MEM_valid,
  input  logic [4:0]  EX_MEM_rd,
  input  logic        EX_MEM_regwrite,
  input  logic        EX_MEM_memread,
  input  logic        EX_MEM_memwrite,
  input  logic        EX_MEM_memtoreg,
  input  logic [2:0]  EX_MEM_funct3,
  input  logic [31:0] EX_MEM_ALU_result,
  input  logic [31:0] EX_MEM_rs2_data,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_wstrb,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic [4:0]  MEM_WB_rd,
  output logic [31:0] MEM_WB_result,
  output logic        MEM_WB_regwrite,
  output logic        MEM_stall,
  output logic        MEM_misaligned,
  output logic        MEM_bus_error
);

  // Last REQ cycle count value before the access is abandoned
  localparam logic [15:0] c_timeout_last = 16'(TIMEOUT_CYCLES - 1);

  mem_state_e  r_state;
  logic [15:0] r_cnt;
  logic        r_req;
  logic        r_we;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [3:0]  r_wstrb;
  logic        r_misaligned;
  logic        r_bus_error;
  logic [4:0]  r_wb_rd;
  logic [31:0] r_wb_result;
  logic        r_wb_regwrite;

  logic        w_mem_op;
  logic        w_is_store;
  logic        w_bad;
  logic        w_bad_op;
  logic        w_good_op;
  logic        w_ack_done;
  logic        w_timeout;
  logic        w_stall;
  logic [3:0]  w_wstrb;
  logic [31:0] w_wdata;
  logic [31:0] w_load_result;

  mem_lane_align u_align (
    .i_addr_lo  (EX_MEM_ALU_result[1:0]),
    .i_funct3   (EX_MEM_funct3),
    .i_is_store (w_is_store),
    .i_rs2      (EX_MEM_rs2_data),
    .i_rdata    (dmem_rdata),
    .o_wstrb    (w_wstrb),
    .o_wdata    (w_wdata),
    .o_bad      (w_bad),
    .o_result   (w_load_result)
  );

  assign w_is_store = EX_MEM_memwrite;
  assign w_mem_op   = EX_MEM_valid & (EX_MEM_memread | EX_MEM_memwrite);
  assign w_bad_op   = w_mem_op & w_bad;
  assign w_good_op  = w_mem_op & ~w_bad;
  assign w_ack_done = (r_state == ST_REQ) & dmem_ack;
  assign w_timeout  = (r_state == ST_REQ) & ~dmem_ack & (r_cnt == c_timeout_last);
  // Release upstream on the completing cycle (ack or timeout), never for bad ops
  assign w_stall    = w_good_op & ~w_ack_done & ~w_timeout;

  assign dmem_req        = r_req;
  assign dmem_we         = r_we;
  assign dmem_addr       = r_addr;
  assign dmem_wdata      = r_wdata;
  assign dmem_wstrb      = r_wstrb;
  assign MEM_WB_rd       = r_wb_rd;
  assign MEM_WB_result   = r_wb_result;
  assign MEM_WB_regwrite = r_wb_regwrite;
  assign MEM_stall       = w_stall;
  assign MEM_misaligned  = r_misaligned;
  assign MEM_bus_error   = r_bus_error;

  // Access FSM: launches the bus request, counts REQ cycles, retires on ack or timeout
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_cnt        <= 16'd0;
      r_req        <= 1'b0;
      r_we         <= 1'b0;
      r_addr       <= 32'd0;
      r_wdata      <= 32'd0;
      r_wstrb      <= 4'b0000;
      r_misaligned <= 1'b0;
      r_bus_error  <= 1'b0;
    end else begin
      r_misaligned <= w_bad_op;
      r_bus_error  <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_good_op) begin
            r_state <= ST_REQ;
            r_cnt   <= 16'd0;
            r_req   <= 1'b1;
            r_we    <= w_is_store;
            r_addr  <= {EX_MEM_ALU_result[31:2], 2'b00};
            r_wdata <= w_is_store ? w_wdata : 32'd0;
            r_wstrb <= w_is_store ? w_wstrb : 4'b0000;
          end
        end
        ST_REQ: begin
          if (dmem_ack || w_timeout) begin
            r_state     <= ST_IDLE;
            r_req       <= 1'b0;
            r_we        <= 1'b0;
            r_addr      <= 32'd0;
            r_wdata     <= 32'd0;
            r_wstrb     <= 4'b0000;
            r_bus_error <= w_timeout;
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // MEM/WB register: bubble while stalled, otherwise retire the current instruction
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wb_rd       <= 5'd0;
      r_wb_result   <= 32'd0;
      r_wb_regwrite <= 1'b0;
    end else if (w_stall) begin
      r_wb_rd       <= 5'd0;
      r_wb_regwrite <= 1'b0;
    end else if (!EX_MEM_valid || w_bad_op || w_timeout) begin
      r_wb_regwrite <= 1'b0;
    end else if (w_mem_op) begin
      r_wb_rd       <= EX_MEM_rd;
      r_wb_result   <= EX_MEM_memtoreg ? w_load_result : EX_MEM_ALU_result;
      r_wb_regwrite <= EX_MEM_regwrite & ~w_is_store;
    end else begin
      r_wb_rd       <= EX_MEM_rd;
      r_wb_result   <= EX_MEM_ALU_result;
      r_wb_regwrite <= EX_MEM_regwrite;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_stage
// Summary  : Self-checking bench for mem_stage: directed scenarios followed by
//            randomized loads/stores/ALU ops against a behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_stage;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        EX_MEM_valid;
  logic [4:0]  EX_MEM_rd;
  logic        EX_MEM_regwrite;
  logic        EX_MEM_memread;
  logic        EX_MEM_memwrite;
  logic        EX_MEM_memtoreg;
  logic [2:0]  EX_MEM_funct3;
  logic [31:0] EX_MEM_ALU_result;
  logic [31:0] EX_MEM_rs2_data;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_wstrb;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;
  logic [4:0]  MEM_WB_rd;
  logic [31:0] MEM_WB_result;
  logic        MEM_WB_regwrite;
  logic        MEM_stall;
  logic        MEM_misaligned;
  logic        MEM_bus_error;

  int          n_total = 0;
  int          n_bad   = 0;
  int          cap_stall;
  int          cap_req;
  logic        cap_we;
  logic [31:0] cap_addr;
  logic [31:0] cap_wdata;
  logic [3:0]  cap_wstrb;
  logic [2:0]  ld_f3 [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};

  always #5 clk = ~clk;

  mem_stage #(.TIMEOUT_CYCLES(TO)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .EX_MEM_valid      (EX_MEM_valid),
    .EX_MEM_rd         (EX_MEM_rd),
    .EX_MEM_regwrite   (EX_MEM_regwrite),
    .EX_MEM_memread    (EX_MEM_memread),
    .EX_MEM_memwrite   (EX_MEM_memwrite),
    .EX_MEM_memtoreg   (EX_MEM_memtoreg),
    .EX_MEM_funct3     (EX_MEM_funct3),
    .EX_MEM_ALU_result (EX_MEM_ALU_result),
    .EX_MEM_rs2_data   (EX_MEM_rs2_data),
    .dmem_req          (dmem_req),
    .dmem_we           (dmem_we),
    .dmem_addr         (dmem_addr),
    .dmem_wdata        (dmem_wdata),
    .dmem_wstrb        (dmem_wstrb),
    .dmem_ack          (dmem_ack),
    .dmem_rdata        (dmem_rdata),
    .MEM_WB_rd         (MEM_WB_rd),
    .MEM_WB_result     (MEM_WB_result),
    .MEM_WB_regwrite   (MEM_WB_regwrite),
    .MEM_stall         (MEM_stall),
    .MEM_misaligned    (MEM_misaligned),
    .MEM_bus_error     (MEM_bus_error)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // ---- reference model: access size, legality, lanes, extension ----
  function automatic int acc_size(input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   return 1;
      2'b01:   return 2;
      default: return 4;
    endcase
  endfunction

  function automatic bit is_legal(input logic [2:0] f3, input bit store);
    if (store) return (f3 <= 3'd2);
    return (f3 <= 3'd2) || (f3 == 3'd4) || (f3 == 3'd5);
  endfunction

  function automatic logic [3:0] exp_strb(input logic [2:0] f3, input logic [31:0] addr);
    int sz;
    sz = acc_size(f3);
    return 4'(((1 << sz) - 1) << (addr % 4));
  endfunction

  function automatic logic [31:0] exp_wdata(input logic [2:0] f3, input logic [31:0] rs2);
    case (acc_size(f3))
      1:       return (rs2 % 256) * 32'h0101_0101;
      2:       return (rs2 % 65536) * 32'h0001_0001;
      default: return rs2;
    endcase
  endfunction

  function automatic logic [31:0] exp_load(input logic [2:0] f3, input logic [31:0] addr,
                                           input logic [31:0] rdata);
    int     sz;
    longint v;
    longint full;
    sz = acc_size(f3);
    if (sz == 4) return rdata;
    full = longint'(1) << (8 * sz);
    v    = longint'(rdata >> (8 * (addr % 4))) % full;
    if (f3[2] == 1'b0 && v >= full / 2) v = v - full;
    return v[31:0];
  endfunction

  task automatic clear_inputs();
    EX_MEM_valid      = 1'b0;
    EX_MEM_rd         = 5'd0;
    EX_MEM_regwrite   = 1'b0;
    EX_MEM_memread    = 1'b0;
    EX_MEM_memwrite   = 1'b0;
    EX_MEM_memtoreg   = 1'b0;
    EX_MEM_funct3     = 3'd0;
    EX_MEM_ALU_result = 32'd0;
    EX_MEM_rs2_data   = 32'd0;
  endtask

  // Presents one instruction at cycle 0 (caller sits just after an edge), acks
  // in REQ cycle ack_at (ack_at > TO means never), and checks the whole access.
  // Returns just after the retiring edge with the instruction still applied.
  task automatic do_op(input logic v, input logic [4:0] rd, input logic rw,
                       input logic mr, input logic mw, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] rs2,
                       input int ack_at, input logic [31:0] rdata);
    bit mem;
    bit bad;
    bit done;
    int sz;
    int c;
    mem = v && (mr || mw);
    sz  = acc_size(f3);
    bad = mem && (!is_legal(f3, mw) || ((addr % 4) % sz) != 0);
    EX_MEM_valid      = v;
    EX_MEM_rd         = rd;
    EX_MEM_regwrite   = rw;
    EX_MEM_memread    = mr;
    EX_MEM_memwrite   = mw;
    EX_MEM_memtoreg   = mr;
    EX_MEM_funct3     = f3;
    EX_MEM_ALU_result = addr;
    EX_MEM_rs2_data   = rs2;
    cap_stall = 0;
    cap_req   = 0;
    #1;
    if (!mem || bad) begin
      chk("stall_nomem", MEM_stall, 0);
      chk("req_nomem", dmem_req, 0);
      @(posedge clk); #1;
      chk("wb_we_nomem", MEM_WB_regwrite, (v && !mem) ? rw : 1'b0);
      if (v && !mem) begin
        chk("wb_rd_alu", MEM_WB_rd, rd);
        chk("wb_res_alu", MEM_WB_result, addr);
      end
      chk("misaligned", MEM_misaligned, bad);
      chk("req_after_nomem", dmem_req, 0);
      if (bad) begin
        clear_inputs();
        @(posedge clk); #1;
        chk("misaligned_pulse", MEM_misaligned, 0);
      end
      return;
    end
    chk("stall_c0", MEM_stall, 1);
    chk("req_c0", dmem_req, 0);
    if (MEM_stall) cap_stall++;
    done = 0;
    c    = 1;
    while (!done && c <= TO) begin
      @(posedge clk); #1;
      chk("req_on", dmem_req, 1);
      chk("we", dmem_we, mw);
      chk("addr", dmem_addr, addr & 32'hFFFF_FFFC);
      chk("wb_bubble_we", MEM_WB_regwrite, 0);
      chk("wb_bubble_rd", MEM_WB_rd, 0);
      if (mw) begin
        chk("wstrb", dmem_wstrb, exp_strb(f3, addr));
        chk("wdata", dmem_wdata, exp_wdata(f3, rs2));
      end
      if (dmem_req) cap_req++;
      cap_we    = dmem_we;
      cap_addr  = dmem_addr;
      cap_wdata = dmem_wdata;
      cap_wstrb = dmem_wstrb;
      if (c == ack_at) begin
        dmem_ack   = 1'b1;
        dmem_rdata = rdata;
        #1;
        chk("stall_ack", MEM_stall, 0);
        done = 1;
      end else if (c == TO) begin
        chk("stall_timeout", MEM_stall, 0);
        done = 1;
      end else begin
        chk("stall_wait", MEM_stall, 1);
        if (MEM_stall) cap_stall++;
      end
      c++;
    end
    @(posedge clk); #1;
    dmem_ack   = 1'b0;
    dmem_rdata = $urandom;
    chk("req_off", dmem_req, 0);
    if (ack_at <= TO) begin
      chk("bus_err_none", MEM_bus_error, 0);
      if (mw) begin
        chk("wb_we_store", MEM_WB_regwrite, 0);
      end else begin
        chk("wb_we_load", MEM_WB_regwrite, rw);
        chk("wb_rd_load", MEM_WB_rd, rd);
        chk("wb_res_load", MEM_WB_result, exp_load(f3, addr, rdata));
      end
    end else begin
      chk("bus_err", MEM_bus_error, 1);
      chk("wb_we_timeout", MEM_WB_regwrite, 0);
      clear_inputs();
      @(posedge clk); #1;
      chk("bus_err_pulse", MEM_bus_error, 0);
      chk("req_idle_after_to", dmem_req, 0);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0]  r_f3;
    logic [31:0] r_ad;
    int          kind;
    bit          st;

    rst_n      = 1'b0;
    dmem_ack   = 1'b0;
    dmem_rdata = 32'd0;
    clear_inputs();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req", dmem_req, 0);
    chk("rst_we", dmem_we, 0);
    chk("rst_addr", dmem_addr, 0);
    chk("rst_wdata", dmem_wdata, 0);
    chk("rst_wstrb", dmem_wstrb, 0);
    chk("rst_wb_rd", MEM_WB_rd, 0);
    chk("rst_wb_res", MEM_WB_result, 0);
    chk("rst_wb_we", MEM_WB_regwrite, 0);
    chk("rst_stall", MEM_stall, 0);
    chk("rst_misal", MEM_misaligned, 0);
    chk("rst_buserr", MEM_bus_error, 0);
    rst_n = 1'b1;

    // ALU passthrough
    do_op(1, 5'd5, 1, 0, 0, 3'd0, 32'h1234, 32'd0, 1, 32'd0);
    chk("alu_rd", MEM_WB_rd, 5);
    chk("alu_res", MEM_WB_result, 32'h1234);
    chk("alu_we", MEM_WB_regwrite, 1);

    // LB / LBU with ack in the third REQ cycle
    do_op(1, 5'd7, 1, 1, 0, 3'd0, 32'h103, 32'd0, 3, 32'h80FF_FFFF);
    chk("lb_res", MEM_WB_result, 32'hFFFF_FF80);
    chk("lb_addr", cap_addr, 32'h100);
    chk("lb_stall_cycles", cap_stall, 3);
    do_op(1, 5'd7, 1, 1, 0, 3'd4, 32'h103, 32'd0, 3, 32'h80FF_FFFF);
    chk("lbu_res", MEM_WB_result, 32'h80);

    // SH upper half with immediate ack
    do_op(1, 5'd9, 1, 0, 1, 3'd1, 32'h202, 32'hABCD_1234, 1, 32'd0);
    chk("sh_we", cap_we, 1);
    chk("sh_wstrb", cap_wstrb, 4'b1100);
    chk("sh_wdata", cap_wdata, 32'h1234_1234);
    chk("sh_wb_we", MEM_WB_regwrite, 0);

    // Misaligned LW
    do_op(1, 5'd3, 1, 1, 0, 3'd2, 32'h101, 32'd0, 1, 32'd0);
    chk("lw_mis_wb_we", MEM_WB_regwrite, 0);

    // Timeout: ack never comes
    do_op(1, 5'd4, 1, 1, 0, 3'd2, 32'h40, 32'd0, TO + 5, 32'd0);
    chk("to_req_cycles", cap_req, TO);
    chk("to_stall_cycles", cap_stall, TO);

    // Reset in the second REQ cycle, then a late ack
    do_op(1, 5'd2, 1, 0, 0, 3'd0, 32'hDEAD_BEEF, 32'd0, 1, 32'd0);
    EX_MEM_valid      = 1'b1;
    EX_MEM_rd         = 5'd6;
    EX_MEM_regwrite   = 1'b1;
    EX_MEM_memread    = 1'b1;
    EX_MEM_memwrite   = 1'b0;
    EX_MEM_memtoreg   = 1'b1;
    EX_MEM_funct3     = 3'd2;
    EX_MEM_ALU_result = 32'h80;
    @(posedge clk); #1;
    chk("rstreq_req1", dmem_req, 1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    clear_inputs();
    #1;
    chk("rstreq_req", dmem_req, 0);
    chk("rstreq_addr", dmem_addr, 0);
    chk("rstreq_wb_we", MEM_WB_regwrite, 0);
    chk("rstreq_wb_res", MEM_WB_result, 0);
    chk("rstreq_stall", MEM_stall, 0);
    @(posedge clk); #1;
    rst_n      = 1'b1;
    dmem_ack   = 1'b1;
    dmem_rdata = 32'h5555_AAAA;
    @(posedge clk); #1;
    chk("late_ack_req", dmem_req, 0);
    chk("late_ack_wb_we", MEM_WB_regwrite, 0);
    dmem_ack = 1'b0;
    do_op(1, 5'd6, 1, 1, 0, 3'd5, 32'h86, 32'd0, 2, 32'hC001_7FFF);
    chk("post_rst_lhu", MEM_WB_result, 32'h0000_C001);

    // Randomized mix against the model
    for (int i = 0; i < 60; i++) begin
      kind = $urandom_range(0, 9);
      st   = (kind >= 7);
      if ($urandom_range(0, 3) == 0) r_f3 = 3'($urandom_range(0, 7));
      else if (st)                   r_f3 = 3'($urandom_range(0, 2));
      else                           r_f3 = ld_f3[$urandom_range(0, 4)];
      r_ad = $urandom;
      if ($urandom_range(0, 3) != 0) r_ad = r_ad & ~32'(acc_size(r_f3) - 1);
      if (kind == 3)
        do_op(0, 5'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), r_f3, r_ad,
              $urandom, 1, $urandom);
      else
        do_op(1, 5'($urandom), 1'($urandom), (kind >= 4 && kind <= 6), st, r_f3, r_ad,
              $urandom, $urandom_range(1, TO + 1), $urandom);
    end
    clear_inputs();
    repeat (2) @(posedge clk);
    #1;
    chk("end_req", dmem_req, 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mem_stage.md
# mem_stage

Memory stage of the five-stage pipeline: consumes the EX/MEM register and performs data-memory loads and stores over a req/ack bus. Produces the registered MEM/WB triple (`MEM_WB_rd`, `MEM_WB_result`, `MEM_WB_regwrite`), which is the write-back and forwarding source read by the EX-stage hazard logic. Holds the upstream pipeline with `MEM_stall` while a memory access is outstanding.

## Interface
- `TIMEOUT_CYCLES`, 255: REQ cycles without `dmem_ack` before the access is aborted (1..65535).
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `EX_MEM_valid` in 1: the EX/MEM register holds a real instruction.
- `EX_MEM_rd` in 5: destination register.
- `EX_MEM_regwrite` in 1: instruction writes `rd`.
- `EX_MEM_memread` in 1: load.
- `EX_MEM_memwrite` in 1: store.
- `EX_MEM_memtoreg` in 1: result comes from memory.
- `EX_MEM_funct3` in 3: access size/sign.
- `EX_MEM_ALU_result` in 32: effective address, or the ALU result for non-memory instructions.
- `EX_MEM_rs2_data` in 32: store data.
- `dmem_req` out 1: bus request, registered.
- `dmem_we` out 1: write enable.
- `dmem_addr` out 32: word-aligned address (`[1:0]`=0).
- `dmem_wdata` out 32: store data replicated into byte lanes.
- `dmem_wstrb` out 4: byte strobes.
- `dmem_ack` in 1: access complete; `dmem_rdata` is valid in the same cycle.
- `dmem_rdata` in 32: read word.
- `MEM_WB_rd` out 5: registered destination.
- `MEM_WB_result` out 32: registered write-back and forward data.
- `MEM_WB_regwrite` out 1: registered write enable.
- `MEM_stall` out 1: combinational hold request to IF/ID/EX.
- `MEM_misaligned` out 1: one-cycle registered pulse on a misaligned access or illegal `funct3`.
- `MEM_bus_error` out 1: one-cycle registered pulse on timeout.

## Operation
- Memory op: `mem_op = EX_MEM_valid & (memread | memwrite)`.
- Load `funct3` encodings:
  - 000 LB and 100 LBU: any address.
  - 001 LH and 101 LHU: `addr[0]`=0.
  - 010 LW: `addr[1:0]`=0.
- Store `funct3` encodings: 000 SB, 001 SH, 010 SW, with the same alignment rules.
- Any other `funct3`, or an alignment failure (a "bad op"):
  - no bus request is issued;
  - `MEM_misaligned` pulses;
  - `MEM_WB_regwrite`←0;
  - `MEM_stall` stays low.
- FSM has two states, IDLE and REQ.
  - IDLE with a good `mem_op` → REQ. `dmem_req`/`we`/`addr`/`wdata`/`wstrb` are registered at this edge; the timeout counter is cleared.
  - REQ with `dmem_ack` → IDLE. `dmem_req` drops; MEM/WB is written.
  - REQ with counter = `TIMEOUT_CYCLES`-1 and no ack → IDLE. `MEM_bus_error` pulses; MEM/WB is written with `regwrite`=0.
  - `dmem_ack` is ignored in IDLE.
- `MEM_stall = mem_op & ~bad & ~(state==REQ & dmem_ack)`, and is forced to 0 on the timeout cycle.
- Store strobes, where `a = addr[1:0]`:
  - SB: `wstrb = 1<<a`, `wdata = {4{rs2[7:0]}}`.
  - SH: `wstrb = 0011<<a`, `wdata = {2{rs2[15:0]}}`.
  - SW: `wstrb = 1111`, `wdata = rs2`.
- Load result: select the lane from `dmem_rdata` by `addr[1:0]`, then sign- or zero-extend per `funct3`.
- MEM/WB update on every edge where `MEM_stall`=0:
  - Non-memory valid instruction: `rd`, `regwrite`, and `result` = `ALU_result`.
  - Completed load: `result` = extended data; `regwrite` = `EX_MEM_regwrite`.
  - Completed store: `regwrite`←0.
  - `EX_MEM_valid`=0: `regwrite`←0.
- While stalled, MEM/WB loads a bubble (`regwrite`=0, `rd`=0), so WB cannot retire the same instruction twice.
- The `rd`=0 write is passed through as-is; the consumers qualify it.

## Timing
- Reset values:
  - all outputs 0;
  - state IDLE;
  - counter 0.
- Reset asserted mid-REQ abandons the access at once: `dmem_req` drops asynchronously, and no MEM/WB write occurs.
- Non-memory latency: EX/MEM to MEM/WB in 1 edge.
- Memory access, with the op present at cycle 0:
  - `dmem_req` is high from cycle 1;
  - with ack in cycle k≥1, MEM/WB is valid after the edge ending cycle k;
  - `MEM_stall` is high in cycles 0..k-1 and low in cycle k.
- Minimum load-to-MEM/WB is 2 edges.
- Request outputs are held stable while `dmem_req`=1.
- Back-to-back memory ops:
  - the next op arrives at cycle k+1 and starts a new REQ at cycle k+2;
  - `dmem_req` is low for at least 1 cycle between accesses.

## Structure
- Package `pipeline_pkg`:
  - opcode constants `OP_*`;
  - `funct3` constants `F3_LB`…`F3_SW`;
  - FSM state encoding.
- Sub-module `mem_lane_align` (combinational):
  - store path: address and `funct3` → `wstrb`, `wdata`, `bad`;
  - load path: `rdata`, `addr[1:0]`, `funct3` → extended `result`.
- FSM, counter and MEM/WB register live in `mem_stage`.

## Test plan
- ALU passthrough: `valid`=1, `regwrite`=1, `rd`=5, `ALU_result`=0x1234, no mem op → next edge `MEM_WB_rd`=5, `result`=0x1234, `regwrite`=1, `MEM_stall`=0 throughout.
- LB, ack after 3 REQ cycles: `addr`=0x103, `rdata`=0x80FF_FFFF:
  - `dmem_addr`=0x100, `MEM_stall` high for 3 cycles then low;
  - `MEM_WB_result`=0xFFFF_FF80; with LBU the result is 0x80.
- SH at `addr`=0x202, `rs2`=0xABCD_1234, immediate ack:
  - `dmem_we`=1, `wstrb`=1100, `wdata`=0x1234_1234;
  - `MEM_WB_regwrite`=0 afterwards.
- LW at `addr`=0x101 → no `dmem_req`, `MEM_misaligned` pulse for 1 cycle, `MEM_WB_regwrite`=0, no stall.
- `TIMEOUT_CYCLES`=4, ack never asserted → `dmem_req` high for exactly 4 cycles, `MEM_bus_error` pulse, `MEM_stall` low on the 4th cycle, FSM back in IDLE.
- `rst_n` pulled low in the 2nd REQ cycle, then a late ack → all outputs 0 immediately; the ack after release is ignored, and the next op issues cleanly.
